// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: N_REQ requesters compete to write one shared DW-bit register.
// One requester is granted per arbitration, the grant lasts one cycle, and GAP_CYC
// idle cycles follow each grant before the next arbitration.
//
// Policy: define SHARED_REG_ARB_RR_EN for round-robin arbitration (search upward
// from a rotating pointer); leave it undefined for fixed priority (lowest index wins).
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester write request, held until granted
//   wr_data  per-requester write data, slice i = [i*DW +: DW]
//   gnt      registered one-hot grant
//   q        shared register contents
//   q_valid  q has been written at least once since reset
//   q_owner  index of the requester that last wrote q
//   busy     arbiter is in GRANT or GAP
module shared_reg_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      wr_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [DW-1:0]            q,
    output logic                     q_valid,
    output logic [$clog2(N_REQ)-1:0] q_owner,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [IW-1:0]     win, win_n;
    logic [IW-1:0]     sel;
    logic [CW-1:0]     cnt, cnt_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [DW-1:0]     q_n;
    logic              q_valid_n;
    logic [IW-1:0]     q_owner_n;
    logic              busy_n;
    logic              any_req;

`ifdef SHARED_REG_ARB_RR_EN
    logic [IW-1:0]     ptr, ptr_n;
`endif

    assign any_req = |req;

    // Winner selection from the live request vector.
`ifdef SHARED_REG_ARB_RR_EN
    always_comb begin
        logic        found;
        int unsigned idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = IW'(i);
            end
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        win_n     = win;
        cnt_n     = cnt;
        gnt_n     = '0;
        q_n       = q;
        q_valid_n = q_valid;
        q_owner_n = q_owner;
`ifdef SHARED_REG_ARB_RR_EN
        ptr_n     = ptr;
`endif
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    gnt_n   = N_REQ'(1) << sel;
                    win_n   = sel;
                    state_n = S_GRANT;
`ifdef SHARED_REG_ARB_RR_EN
                    // Explicit wrap keeps non-power-of-two N_REQ in range.
                    ptr_n   = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
`endif
                end
            end
            S_GRANT: begin
                // A withdrawn request forfeits its write but still consumes the turn.
                if (req[win]) begin
                    q_n       = wr_data[32'(win)*DW +: DW];
                    q_owner_n = win;
                    q_valid_n = 1'b1;
                end
                if (GAP_CYC != 0) begin
                    state_n = S_GAP;
                    cnt_n   = CW'(GAP_CYC - 1);
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and output registers; reset overrides any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            win     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            q_owner <= '0;
            busy    <= 1'b0;
`ifdef SHARED_REG_ARB_RR_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_n;
            win     <= win_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            q       <= q_n;
            q_valid <= q_valid_n;
            q_owner <= q_owner_n;
            busy    <= busy_n;
`ifdef SHARED_REG_ARB_RR_EN
            ptr     <= ptr_n;
`endif
        end
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 8, width of shared storage register.
REQ-003 Parameter GAP_CYC, default 1, idle cycles forced after each grant (0..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N_REQ  per-requester write request, held until granted.
REQ-007 wr_data  input  N_REQ*DW  per-requester write data, slice i = bits [i*DW +: DW].
REQ-008 gnt  output  N_REQ  registered one-hot grant, at most one bit set.
REQ-009 q  output  DW  shared register contents (edge-triggered D flip-flops).
REQ-010 q_valid  output  1  set once q holds any written value.
REQ-011 q_owner  output  clog2(N_REQ)  index of requester that last wrote q.
REQ-012 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 FSM states IDLE, GRANT, GAP; encoding free; no other reachable states.
REQ-014 IDLE: if any req bit set at edge, select winner, load gnt one-hot, go GRANT; else stay IDLE, gnt=0.
REQ-015 Grant latency: req seen high in cycle t -> gnt high in cycle t+1 exactly.
REQ-016 GRANT lasts exactly one cycle; gnt cleared at the edge ending it.
REQ-017 GRANT, req[winner] still high: at edge ending GRANT, q <= wr_data slice winner, q_owner <= winner, q_valid <= 1.
REQ-018 GRANT, req[winner] low (withdrawn): no write; q, q_owner, q_valid unchanged; arbitration pointer still advances.
REQ-019 Leaving GRANT: go GAP if GAP_CYC>0 with counter loaded GAP_CYC-1; else go IDLE.
REQ-020 GAP: no grant issued, requests ignored; counter decrements each cycle; at count 0 go IDLE.
REQ-021 Earliest next grant after a grant in cycle t+1: cycle t+3+GAP_CYC.
REQ-022 Requests arriving during GRANT/GAP are not lost as long as held; evaluated in next IDLE cycle.
REQ-023 Requester shall drop req after the cycle gnt is seen; a req still high in IDLE is treated as a new request.
REQ-024 busy = 1 in GRANT and GAP, 0 in IDLE.
REQ-025 Arbitration pointer ptr (clog2(N_REQ) bits): after any grant, ptr <= winner+1, wrapping N_REQ-1 -> 0.

Reset
REQ-026 rst high at edge: FSM IDLE, gnt=0, q=0, q_valid=0, q_owner=0, ptr=0, gap counter=0, busy=0.
REQ-027 rst asserted during GRANT cancels the pending write; rst overrides all other events in the same cycle.
REQ-028 First grant possible in cycle after rst deasserts, request sampled in that cycle.

Configuration
REQ-029 Macro SHARED_REG_ARB_RR_EN selects arbitration policy.
REQ-030 Defined: round-robin; winner = first set req bit searching upward from ptr, wrapping.
REQ-031 Undefined: fixed priority; lowest-index set req bit wins; ptr logic and REQ-025 absent, fairness not guaranteed.
REQ-032 Timing, FSM, reset and write behaviour identical in both builds.

Verification
REQ-033 N_REQ=4, DW=8, GAP_CYC=1; after reset req=0001, wr_data slice0=0xA5 -> gnt=0001 one cycle later, next cycle q=0xA5, q_owner=0, q_valid=1.
REQ-034 req=1111 held continuously, slices 0x10,0x11,0x12,0x13, RR build -> grants 0001,0010,0100,1000,0001 spaced 3 cycles apart; q follows 0x10..0x13.
REQ-035 Same stimulus, fixed build, requesters dropping req after grant -> grant order 0,1,2,3; with req held forever -> requester 0 only.
REQ-036 req=0100 granted, req withdrawn in GRANT cycle -> q, q_owner, q_valid unchanged; next RR search starts at index 3.
REQ-037 rst pulsed in GRANT cycle of req=0010, data 0x5A -> q=0, q_valid=0, gnt=0, busy=0 next cycle.
REQ-038 GAP_CYC=0 and GAP_CYC=15, single held request per turn -> grant spacing 2 and 17 cycles respectively; busy high exactly 1 and 16 cycles per grant.
